// File: rtl/mpu_dispatch_seq_pkg.sv
// Shared types and defaults for the MPU dispatch sequencer.
// Thread ID, instruction and address widths match the TPU instruction port.
package mpu_dispatch_seq_pkg;

  localparam int unsigned SIZE_THREAD_MEM_DFLT = 1024;
  localparam int unsigned DEPTH_PEND_DFLT      = 8;
  localparam int unsigned ID_W                 = 8;
  localparam int unsigned INSTR_W              = 32;
  localparam int unsigned ADDR_W               = $clog2(SIZE_THREAD_MEM_DFLT);

  typedef logic [ID_W-1:0]    id_t;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [ADDR_W-1:0]  t_address_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    ISSUE,
    DRAIN
  } fsm_dispatch_t;

  // Instruction memory addresses wrap modulo its depth.
  function automatic t_address_t addr_next(input t_address_t a, input int unsigned size);
    return (32'(a) == size - 1) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/mpu_dispatch_seq_queue.sv
// Pending thread-ID queue: ring-buffer pointer control plus an ID array.
// A push while full is dropped and latches a sticky overflow flag until reset.
import mpu_dispatch_seq_pkg::*;

module mpu_dispatch_seq_queue #(
  parameter int unsigned NUM_ENTRY = DEPTH_PEND_DFLT
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  id_t  push_id,
  input  logic pop,
  output id_t  head_id,
  output logic full,
  output logic empty,
  output logic overflow
);

  localparam int unsigned PTR_W = $clog2(NUM_ENTRY);

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  id_t            mem [NUM_ENTRY];
  logic           do_push;
  logic           do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head_id = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_id;
  end

endmodule

// File: rtl/mpu_dispatch_seq.sv
// Dispatch sequencer: queues ready threads, looks up base/length via MapMan,
// streams the thread's instructions from thread memory to the TPU, then signals end.
import mpu_dispatch_seq_pkg::*;

module mpu_dispatch_seq #(
  parameter int unsigned SIZE_THREAD_MEM = SIZE_THREAD_MEM_DFLT,
  parameter int unsigned DEPTH_PEND      = DEPTH_PEND_DFLT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       I_Req,
  input  id_t        I_ThreadID,
  output logic       O_Full,
  output logic       O_Req_Lookup,
  output id_t        O_ThreadID_Lookup,
  input  logic       I_Ack_Lookup,
  input  t_address_t I_Base_Addr,
  input  t_address_t I_Length,
  output logic       O_Req_Ld,
  output t_address_t O_Address_Ld,
  input  instr_t     I_Instr_Ld,
  input  logic       I_Stall,
  output logic       O_Req_Issue,
  output instr_t     O_Instr,
  output logic       O_End,
  output id_t        O_ThreadID_End,
  output logic       O_Busy
);

  fsm_dispatch_t state;
  id_t           r_thread_id;
  t_address_t    r_addr;
  t_address_t    r_rem;
  id_t           q_head;
  logic          q_full;
  logic          q_empty;
  logic          pend_overflow;

  mpu_dispatch_seq_queue #(
    .NUM_ENTRY(DEPTH_PEND)
  ) u_pend (
    .clock   (clock),
    .reset   (reset),
    .push    (I_Req),
    .push_id (I_ThreadID),
    .pop     (state == IDLE),
    .head_id (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .overflow(pend_overflow)
  );

  assign O_Full            = q_full;
  assign O_Req_Lookup      = (state == LOOKUP);
  assign O_ThreadID_Lookup = r_thread_id;
  assign O_Req_Ld          = (state == ISSUE) && !I_Stall;
  assign O_Address_Ld      = r_addr;
  // Load data is only meaningful alongside its issue strobe; held at zero otherwise.
  assign O_Instr           = O_Req_Issue ? I_Instr_Ld : '0;
  assign O_Busy            = (state != IDLE) || !q_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      r_thread_id    <= '0;
      r_addr         <= '0;
      r_rem          <= '0;
      O_Req_Issue    <= 1'b0;
      O_End          <= 1'b0;
      O_ThreadID_End <= '0;
    end else begin
      O_Req_Issue <= O_Req_Ld;
      O_End       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!q_empty) begin
            r_thread_id <= q_head;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (I_Ack_Lookup) begin
            r_addr <= I_Base_Addr;
            r_rem  <= I_Length;
            if (I_Length == '0) begin
              O_End          <= 1'b1;
              O_ThreadID_End <= r_thread_id;
              state          <= IDLE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (O_Req_Ld) begin
            r_addr <= addr_next(r_addr, SIZE_THREAD_MEM);
            r_rem  <= r_rem - 1'b1;
            if (r_rem == t_address_t'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          O_End          <= 1'b1;
          O_ThreadID_End <= r_thread_id;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_dispatch_seq.sv
// Directed bench for mpu_dispatch_seq: per-cycle vector tables plus
// hand-written queue-overflow and mid-issue reset sequences.
import mpu_dispatch_seq_pkg::*;

module tb_mpu_dispatch_seq;

  localparam instr_t INSTR_TAG = 32'hC0DE_0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       I_Req;
  id_t        I_ThreadID;
  logic       O_Full;
  logic       O_Req_Lookup;
  id_t        O_ThreadID_Lookup;
  logic       I_Ack_Lookup;
  t_address_t I_Base_Addr;
  t_address_t I_Length;
  logic       O_Req_Ld;
  t_address_t O_Address_Ld;
  instr_t     I_Instr_Ld;
  logic       I_Stall;
  logic       O_Req_Issue;
  instr_t     O_Instr;
  logic       O_End;
  id_t        O_ThreadID_End;
  logic       O_Busy;

  mpu_dispatch_seq #(
    .SIZE_THREAD_MEM(1024),
    .DEPTH_PEND     (8)
  ) dut (
    .clock            (clk),
    .reset            (rst_n),
    .I_Req            (I_Req),
    .I_ThreadID       (I_ThreadID),
    .O_Full           (O_Full),
    .O_Req_Lookup     (O_Req_Lookup),
    .O_ThreadID_Lookup(O_ThreadID_Lookup),
    .I_Ack_Lookup     (I_Ack_Lookup),
    .I_Base_Addr      (I_Base_Addr),
    .I_Length         (I_Length),
    .O_Req_Ld         (O_Req_Ld),
    .O_Address_Ld     (O_Address_Ld),
    .I_Instr_Ld       (I_Instr_Ld),
    .I_Stall          (I_Stall),
    .O_Req_Issue      (O_Req_Issue),
    .O_Instr          (O_Instr),
    .O_End            (O_End),
    .O_ThreadID_End   (O_ThreadID_End),
    .O_Busy           (O_Busy)
  );

  always #5 clk = ~clk;

  // Thread memory: one-cycle read latency, data tagged with its address.
  always @(posedge clk) begin
    if (O_Req_Ld) I_Instr_Ld <= INSTR_TAG | instr_t'(O_Address_Ld);
    else          I_Instr_Ld <= 32'hBAD0_BAD0;
  end

  typedef struct {
    logic req; id_t id; logic ack; t_address_t base; t_address_t len; logic stall;
    logic x_lk; id_t x_lk_id; logic x_ld; t_address_t x_addr;
    logic x_iss; instr_t x_instr; logic x_end; id_t x_end_id; logic x_busy;
  } vec_t;

  vec_t        vecs[$];
  id_t         ends[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  function automatic vec_t mk(input int req, id, ack, base, len, stall,
                              input int lk, lk_id, ld, addr, iss, iss_addr, en, end_id, busy);
    vec_t v;
    v.req = (req != 0);   v.id = id_t'(id);         v.ack = (ack != 0);
    v.base = t_address_t'(base); v.len = t_address_t'(len); v.stall = (stall != 0);
    v.x_lk = (lk != 0);   v.x_lk_id = id_t'(lk_id); v.x_ld = (ld != 0);
    v.x_addr = t_address_t'(addr); v.x_iss = (iss != 0);
    v.x_instr = INSTR_TAG | instr_t'(t_address_t'(iss_addr));
    v.x_end = (en != 0);  v.x_end_id = id_t'(end_id); v.x_busy = (busy != 0);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic req, input int id, input logic ack, input int base,
                       input int len, input logic stall);
    I_Req = req; I_ThreadID = id_t'(id); I_Ack_Lookup = ack;
    I_Base_Addr = t_address_t'(base); I_Length = t_address_t'(len); I_Stall = stall;
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[k]) begin
      @(posedge clk); #1;
      drive(vecs[k].req, int'(vecs[k].id), vecs[k].ack, int'(vecs[k].base),
            int'(vecs[k].len), vecs[k].stall);
      @(negedge clk);
      check($sformatf("%s[%0d].req_lookup", tag, k), 32'(O_Req_Lookup), 32'(vecs[k].x_lk));
      if (vecs[k].x_lk)
        check($sformatf("%s[%0d].lookup_id", tag, k), 32'(O_ThreadID_Lookup), 32'(vecs[k].x_lk_id));
      check($sformatf("%s[%0d].req_ld", tag, k), 32'(O_Req_Ld), 32'(vecs[k].x_ld));
      if (vecs[k].x_ld)
        check($sformatf("%s[%0d].addr_ld", tag, k), 32'(O_Address_Ld), 32'(vecs[k].x_addr));
      check($sformatf("%s[%0d].req_issue", tag, k), 32'(O_Req_Issue), 32'(vecs[k].x_iss));
      if (vecs[k].x_iss)
        check($sformatf("%s[%0d].instr", tag, k), O_Instr, vecs[k].x_instr);
      check($sformatf("%s[%0d].end", tag, k), 32'(O_End), 32'(vecs[k].x_end));
      if (vecs[k].x_end)
        check($sformatf("%s[%0d].end_id", tag, k), 32'(O_ThreadID_End), 32'(vecs[k].x_end_id));
      check($sformatf("%s[%0d].busy", tag, k), 32'(O_Busy), 32'(vecs[k].x_busy));
    end
    vecs.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req_lookup"}, 32'(O_Req_Lookup), 0);
    check({tag, ".req_ld"},     32'(O_Req_Ld), 0);
    check({tag, ".req_issue"},  32'(O_Req_Issue), 0);
    check({tag, ".instr"},      O_Instr, 0);
    check({tag, ".end"},        32'(O_End), 0);
    check({tag, ".end_id"},     32'(O_ThreadID_End), 0);
    check({tag, ".busy"},       32'(O_Busy), 0);
    check({tag, ".full"},       32'(O_Full), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 0, 1'b0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // req,id,ack,base,len,stall | lk,lk_id,ld,addr,iss,iss_addr,end,end_id,busy
    // single thread ID 3, base 10, len 4
    vecs.push_back(mk(1, 3, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    1, 3, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 10, 4, 0,   1, 3, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 10, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 11, 1, 10, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 12, 1, 11, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 13, 1, 12, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 13, 0, 0, 1));
    // zero length thread ID 5
    vecs.push_back(mk(1, 5, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 85, 0, 0,   1, 5, 0, 0, 0, 0, 0, 0, 1));
    // address wrap thread ID 7, base 1022, len 4
    vecs.push_back(mk(1, 7, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1022, 4, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 1022, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 1023, 1, 1022, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 0, 1, 1023, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 1, 0, 0, 1));
    // stall for 3 cycles mid-thread, ID 9, base 100, len 8
    vecs.push_back(mk(1, 9, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 7, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 100, 8, 0,  1, 9, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 100, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 101, 1, 100, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 1, 101, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 102, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 103, 1, 102, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 104, 1, 103, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 105, 1, 104, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 106, 1, 105, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 107, 1, 106, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 107, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 9, 0));
    run_vecs("seq");

    // Queue overflow: thread 0x20 parks in LOOKUP, then 9 pushes arrive.
    @(posedge clk); #1; drive(1'b1, 'h20, 1'b0, 0, 0, 1'b0);
    @(posedge clk); #1; drive(1'b0, 0, 1'b0, 0, 0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("queue.lookup_parked", 32'(O_Req_Lookup), 1);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1; drive(1'b1, 'h30 + i, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      check($sformatf("queue.full_at_push%0d", i), 32'(O_Full), (i == 8) ? 1 : 0);
    end
    @(posedge clk); #1; drive(1'b0, 0, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    check("queue.full_after_drop", 32'(O_Full), 1);
    check("queue.lookup_id_held", 32'(O_ThreadID_Lookup), 'h20);
    ends.delete();
    for (int cyc = 0; cyc < 300 && ends.size() < 9; cyc++) begin
      @(posedge clk); #1;
      drive(1'b0, 0, O_Req_Lookup, cyc, 1, 1'b0);
      @(negedge clk);
      if (O_End) ends.push_back(O_ThreadID_End);
    end
    check("queue.end_count", 32'(ends.size()), 9);
    for (int i = 0; i < 9; i++)
      check($sformatf("queue.end_order%0d", i),
            (i < ends.size()) ? 32'(ends[i]) : 32'hFFFF_FFFF, (i == 0) ? 'h20 : 'h30 + i - 1);
    check("queue.full_cleared", 32'(O_Full), 0);
    check("queue.idle_busy", 32'(O_Busy), 0);

    // Reset asserted mid-ISSUE for thread 0x11 (base 50, len 6).
    @(posedge clk); #1; drive(1'b1, 'h11, 1'b0, 0, 0, 1'b0);
    @(posedge clk); #1; drive(1'b0, 0, 1'b0, 0, 0, 1'b0);
    @(posedge clk); #1; drive(1'b0, 0, 1'b1, 50, 6, 1'b0);
    @(posedge clk); #1; drive(1'b0, 0, 1'b0, 0, 0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst.pre_req_ld", 32'(O_Req_Ld), 1);
    check("rst.pre_addr", 32'(O_Address_Ld), 51);
    check("rst.pre_issue", 32'(O_Req_Issue), 1);
    #2; rst_n = 1'b0; #1;
    check_all_zero("rst.async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst.held");
    rst_n = 1'b1;
    vecs.push_back(mk(1, 'h12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 200, 2, 0,  1, 'h12, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 200, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 201, 1, 200, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 201, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 'h12, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vecs("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
